nested_loop_counter: RTL and testbench

- Parametrised multi-level loop counter that generates (x, y, channel, ...) index tuples for CNN convolution and pooling datapaths.
- Successor to the single-level wrap-at-N counter. Adds per-level runtime limits, carry chaining, a start/done FSM and a valid/ready output handshake.
- Sits between layer control and the address generators for feature-map and weight buffers.

---
 rtl/nested_loop_counter.sv | 169 ++++++++++++++++
 tb/tb_nested_loop_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// nested_loop_counter
// Multi-level loop counter producing index tuples (level 0 innermost) for
// CNN convolution/pooling address generation. A start pulse latches the
// per-level inclusive limits and sweeps every tuple once, presenting each
// on a valid/ready handshake; done pulses one cycle after the final tuple
// is accepted.
//
// Optional build macro: NESTED_LOOP_COUNTER_REPEAT_EN
//   Adds cfg_repeat, latched at start. When set, the sweep restarts with no
//   bubble after the final tuple (done still pulses) until abort or reset.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      begin a sweep (honoured only in IDLE)
//   abort      end a running sweep, no done pulse
//   cfg_limit  per-level inclusive limit, level i at [i*CNT_W +: CNT_W]
//   cfg_repeat (optional) continuous sweeps
//   out_valid  tuple on count is valid
//   out_ready  consumer accepts tuple
//   count      current tuple, same packing as cfg_limit
//   level_last bit i set when level i sits at its latched limit
//   busy       sweep running
//   done       one-cycle end-of-sweep pulse
//
// state | meaning
// IDLE  | waiting for start, count held at zero
// RUN   | presenting tuples, advancing on handshake
// DONE  | single-cycle done pulse, then IDLE

module nested_loop_counter #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_LEVELS*CNT_W-1:0] cfg_limit,
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    input  logic                        cfg_repeat,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LEVELS*CNT_W-1:0] count,
    output logic [NUM_LEVELS-1:0]       level_last,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state, state_next;
    logic [NUM_LEVELS*CNT_W-1:0]   limit_q, limit_next;
    logic [NUM_LEVELS*CNT_W-1:0]   count_next;
    logic [NUM_LEVELS*CNT_W-1:0]   count_inc;
    logic                          carry;

`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    logic repeat_q, repeat_next;
    logic rep_pulse_q, rep_pulse_next;
`endif

    // Ripple increment: each level at its limit wraps and passes the carry
    // on; the carry left over after the last level marks the final tuple.
    always_comb begin
        carry     = 1'b1;
        count_inc = count;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (carry) begin
                if (count[i*CNT_W +: CNT_W] == limit_q[i*CNT_W +: CNT_W]) begin
                    count_inc[i*CNT_W +: CNT_W] = '0;
                end else begin
                    count_inc[i*CNT_W +: CNT_W] = count[i*CNT_W +: CNT_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        limit_next = limit_q;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
        repeat_next    = repeat_q;
        rep_pulse_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    limit_next = cfg_limit;
                    count_next = '0;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
                    repeat_next = cfg_repeat;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (out_ready) begin
                    count_next = count_inc;
                    if (carry) begin
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
                        if (repeat_q) begin
                            rep_pulse_next = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
`else
                        state_next = DONE;
`endif
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            limit_q <= '0;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
            repeat_q    <= 1'b0;
            rep_pulse_q <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            count   <= count_next;
            limit_q <= limit_next;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
            repeat_q    <= repeat_next;
            rep_pulse_q <= rep_pulse_next;
`endif
        end
    end

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);

`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    assign done = (state == DONE) | rep_pulse_q;
`else
    assign done = (state == DONE);
`endif

    // Gated by RUN so the flags read zero outside a sweep (limits and count
    // both reset to zero, which would otherwise compare equal).
    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_last
        assign level_last[g] = (state == RUN) &&
                               (count[g*CNT_W +: CNT_W] == limit_q[g*CNT_W +: CNT_W]);
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
module tb_nested_loop_counter;

    localparam int NL = 3;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [NL*CW-1:0] cfg_limit;
    logic             out_valid;
    logic             out_ready;
    logic [NL*CW-1:0] count;
    logic [NL-1:0]    level_last;
    logic             busy;
    logic             done;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    logic             cfg_repeat;
`endif

    int tests = 0;
    int fails = 0;

    nested_loop_counter #(.NUM_LEVELS(NL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_limit  (cfg_limit),
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
        .cfg_repeat (cfg_repeat),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .level_last (level_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l0;
        int l1;
        int l2;
        int mode;        // 0 ready=1, 1 ready toggles from 0, 2 random ready, 3 perturb start/cfg
        int exp_tuples;
        int exp_cycles;  // -1: not checked
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mixed-radix decomposition of the k-th tuple of a sweep.
    function automatic logic [NL*CW-1:0] tuple_at(input int k, input int l0, input int l1, input int l2);
        int lim[3];
        int rem;
        int digit;
        logic [NL*CW-1:0] t;
        lim = '{l0, l1, l2};
        rem = k;
        t   = '0;
        for (int i = 0; i < NL; i++) begin
            digit = rem % (lim[i] + 1);
            rem   = rem / (lim[i] + 1);
            t[i*CW +: CW] = digit[CW-1:0];
        end
        return t;
    endfunction

    function automatic logic [NL-1:0] last_at(input int k, input int l0, input int l1, input int l2);
        int lim[3];
        int rem;
        int digit;
        logic [NL-1:0] b;
        lim = '{l0, l1, l2};
        rem = k;
        b   = '0;
        for (int i = 0; i < NL; i++) begin
            digit = rem % (lim[i] + 1);
            rem   = rem / (lim[i] + 1);
            b[i]  = (digit == lim[i]);
        end
        return b;
    endfunction

    task automatic run_sweep(input vec_t v, input int idx);
        int k;
        int cyc;
        logic r;
        logic [31:0] rnd;
        k   = 0;
        cyc = 0;
        cfg_limit = {v.l2[CW-1:0], v.l1[CW-1:0], v.l0[CW-1:0]};
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d valid_after_start", idx), {31'd0, out_valid}, 32'd1);
        while (out_valid === 1'b1 && cyc < 3000) begin
            case (v.mode)
                0: r = 1'b1;
                1: r = (cyc % 2) == 1;
                2: r = $urandom_range(0, 1) == 1;
                default: begin
                    r = 1'b1;
                    start = 1'b1;
                    rnd = $urandom;
                    cfg_limit = rnd[NL*CW-1:0];
                end
            endcase
            out_ready = r;
            check($sformatf("v%0d count k=%0d", idx, k), {8'd0, count}, {8'd0, tuple_at(k, v.l0, v.l1, v.l2)});
            check($sformatf("v%0d level_last k=%0d", idx, k), {29'd0, level_last}, {29'd0, last_at(k, v.l0, v.l1, v.l2)});
            check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd1);
            if (r) k++;
            cyc++;
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check($sformatf("v%0d cycle_budget", idx), {31'd0, out_valid}, 32'd0);
        check($sformatf("v%0d tuples", idx), k, v.exp_tuples);
        if (v.exp_cycles >= 0) check($sformatf("v%0d sweep_cycles", idx), cyc, v.exp_cycles);
        check($sformatf("v%0d done_pulse", idx), {31'd0, done}, 32'd1);
        check($sformatf("v%0d busy_at_done", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d count_at_done", idx), {8'd0, count}, 32'd0);
        tick();
        check($sformatf("v%0d done_width", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d idle_valid", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{l0:1,   l1:2, l2:1, mode:0, exp_tuples:12,  exp_cycles:12};
        vecs[1] = '{l0:1,   l1:2, l2:1, mode:1, exp_tuples:12,  exp_cycles:24};
        vecs[2] = '{l0:0,   l1:0, l2:0, mode:0, exp_tuples:1,   exp_cycles:1};
        vecs[3] = '{l0:255, l1:0, l2:0, mode:0, exp_tuples:256, exp_cycles:256};
        vecs[4] = '{l0:0,   l1:3, l2:0, mode:1, exp_tuples:4,   exp_cycles:8};
        vecs[5] = '{l0:1,   l1:0, l2:0, mode:3, exp_tuples:2,   exp_cycles:2};
        for (int i = 6; i < 8; i++) begin
            vecs[i].l0   = $urandom_range(0, 3);
            vecs[i].l1   = $urandom_range(0, 3);
            vecs[i].l2   = $urandom_range(0, 3);
            vecs[i].mode = 2;
            vecs[i].exp_tuples = (vecs[i].l0 + 1) * (vecs[i].l1 + 1) * (vecs[i].l2 + 1);
            vecs[i].exp_cycles = -1;
        end

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; cfg_limit = '0;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
        cfg_repeat = 1'b0;
`endif
        tick();
        tick();
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset count", {8'd0, count}, 32'd0);
        check("reset level_last", {29'd0, level_last}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_sweep(vecs[i], i);

        // abort on the 5th accept of a (3,3,3) sweep
        cfg_limit = {8'd3, 8'd3, 8'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("abort pre count", {8'd0, count}, {8'd0, tuple_at(4, 3, 3, 3)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort valid", {31'd0, out_valid}, 32'd0);
        check("abort count", {8'd0, count}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        tick();
        check("abort no_late_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart valid", {31'd0, out_valid}, 32'd1);
        check("restart count", {8'd0, count}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("restart advance", {8'd0, count}, 32'd1);
        // abort in IDLE is ignored; held abort then ends the sweep
        abort = 1'b1;
        tick();
        check("abort_run valid", {31'd0, out_valid}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_idle ignored", {31'd0, out_valid}, 32'd1);
        tick();
        abort = 1'b0;
        check("abort_held valid", {31'd0, out_valid}, 32'd0);

        // reset mid-sweep overrides start
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        check("midreset valid", {31'd0, out_valid}, 32'd0);
        check("midreset count", {8'd0, count}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);

`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
        cfg_repeat = 1'b1;
        cfg_limit  = {8'd0, 8'd0, 8'd1};
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_repeat = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("repeat valid c=%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("repeat count c=%0d", c), {8'd0, count}, c % 2);
            check($sformatf("repeat done c=%0d", c), {31'd0, done}, ((c > 0) && (c % 2 == 0)) ? 32'd1 : 32'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("repeat abort valid", {31'd0, out_valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
